// File: rtl/branch_resolver.sv
// Branch resolver: checks executed branches against their fetch-time
// prediction, streams training events to the predictor through a small
// FIFO, and holds a flush/redirect to the fetcher until it is acknowledged.
module branch_resolver #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              Resolve_Valid,
  input  logic [DATA_W-1:0] Resolve_PC,
  input  logic              Resolve_Pred_Taken,
  input  logic              Resolve_Taken,
  input  logic [DATA_W-1:0] Resolve_Target,
  output logic              Resolve_Ready,
  input  logic              Train_Stall,
  output logic              Train_Ready,
  output logic              Train_Result,
  output logic [DATA_W-1:0] Train_PC,
  output logic              Flush_Out,
  output logic [DATA_W-1:0] Redirect_PC,
  input  logic              Flush_Done,
  output logic [31:0]       Branch_Count,
  output logic [31:0]       Mispredict_Count
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  state_t state, state_nxt;

  // Training FIFO storage: one PC and one outcome bit per slot.
  logic [DEPTH-1:0][DATA_W-1:0] pc_mem;
  logic [DEPTH-1:0]             tk_mem;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [PTR_W:0]               count;

  logic push, pop, mispredict, fifo_nempty;

  // Handshakes come from registered state only, so a same-cycle pop never
  // opens a slot for a same-cycle push.
  always_comb begin
    fifo_nempty   = (count != '0);
    Resolve_Ready = rdy & (state == IDLE) & (count < FULL);
    Train_Ready   = rdy & fifo_nempty & ~Train_Stall;
    push          = Resolve_Valid & Resolve_Ready;
    pop           = Train_Ready;
    mispredict    = push & (Resolve_Pred_Taken != Resolve_Taken);
    Train_PC      = fifo_nempty ? pc_mem[rd_ptr] : '0;
    Train_Result  = fifo_nempty ? tk_mem[rd_ptr] : 1'b0;
  end

  // FSM next state and flush output; rdy low freezes the transition.
  always_comb begin
    state_nxt = state;
    Flush_Out = 1'b0;
    case (state)
      IDLE: begin
        if (mispredict) state_nxt = FLUSH;
      end
      FLUSH: begin
        Flush_Out = 1'b1;
        if (rdy && Flush_Done) state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FIFO pointers, occupancy and storage; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc_mem <= '0;
      tk_mem <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr] <= Resolve_PC;
        tk_mem[wr_ptr] <= Resolve_Taken;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Redirect target is captured on the mispredicting accept and held
  // untouched for the whole flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            Redirect_PC <= '0;
    else if (mispredict) Redirect_PC <= Resolve_Taken ? Resolve_Target
                                                      : Resolve_PC + DATA_W'(4);
  end

  // Statistics counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Branch_Count     <= '0;
      Mispredict_Count <= '0;
    end else begin
      if (push)       Branch_Count     <= Branch_Count + 32'd1;
      if (mispredict) Mispredict_Count <= Mispredict_Count + 32'd1;
    end
  end

endmodule
